// File: rtl/fifo_status_pkg.sv
// rtl/fifo_status_pkg.sv - state encodings and width helper shared by the FIFO status arbiter
package fifo_status_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_ARB    = 3'd1;
   localparam logic [2:0] ST_REQ    = 3'd2;
   localparam logic [2:0] ST_WAIT   = 3'd3;
   localparam logic [2:0] ST_FSH    = 3'd4;
   localparam logic [2:0] ST_TERR   = 3'd5;
   localparam logic [2:0] ST_RCHAIN = 3'd6;

   localparam logic KIND_BURST = 1'b0;
   localparam logic KIND_TAIL  = 1'b1;

   // Channel index width, never narrower than one bit so NCH=1 still has a req_ch port.
   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_status_chan.sv
// rtl/fifo_status_chan.sv - per-channel burst eligibility and tail capture for fifo_status_arb
module fifo_status_chan
   import fifo_status_pkg::*;
#(
   parameter int    CW        = 10,
   parameter int    THRESHOLD = 200,
   parameter int    LSIZE     = 9,
   parameter string MODE      = "LINE"
)(
   input  logic             clock,
   input  logic             rst_n,
   input  logic [CW-1:0]    count_i,
   input  logic             line_tail_i,
   input  logic             frame_tail_i,
   input  logic [LSIZE-1:0] tail_len_i,
   input  logic             clr_i,
   output logic             burst_ok_o,
   output logic             tail_pend_o,
   output logic [LSIZE-1:0] tail_len_o
);

   logic             burst_ok_q;
   logic             pend_q, pend_d;
   logic [LSIZE-1:0] len_q, len_d;
   logic             tail_pulse;

   assign tail_pulse = (MODE == "ONCE") ? frame_tail_i : line_tail_i;

   // A second tail while one is still pending is dropped so the granted length cannot change.
   always_comb begin
      pend_d = pend_q;
      len_d  = len_q;
      if (clr_i) begin
         pend_d = 1'b0;
      end else if (tail_pulse && !pend_q) begin
         pend_d = 1'b1;
         len_d  = tail_len_i;
      end
   end

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         burst_ok_q <= 1'b0;
         pend_q     <= 1'b0;
         len_q      <= '0;
      end else begin
         burst_ok_q <= int'(count_i) > THRESHOLD;
         pend_q     <= pend_d;
         len_q      <= len_d;
      end
   end

   assign burst_ok_o  = burst_ok_q;
   assign tail_pend_o = pend_q;
   assign tail_len_o  = len_q;

endmodule

// File: rtl/fifo_status_arb.sv
// rtl/fifo_status_arb.sv - round-robin FIFO status arbiter toward one AXI burst engine
// Optional timeout / rst_chain recovery when FIFO_STATUS_ARB_TIMEOUT_EN is defined.
module fifo_status_arb
   import fifo_status_pkg::*;
#(
   parameter int              NCH       = 4,
   parameter int              CW        = 10,
   parameter int              THRESHOLD = 200,
   parameter int              BURST_LEN = 100,
   parameter int              LSIZE     = 9,
   parameter string           MODE      = "LINE",
   parameter int              TO_W      = 24,
   parameter logic [TO_W-1:0] TO_LIMIT  = 24'hFFF000
)(
   input  logic                        clock,
   input  logic                        rst_n,
   input  logic                        enable,
   input  logic [NCH-1:0]              f_rst_st,
   input  logic [NCH*CW-1:0]           count,
   input  logic [NCH-1:0]              line_tail,
   input  logic [NCH-1:0]              frame_tail,
   input  logic [NCH*LSIZE-1:0]        tail_len,
   input  logic [NCH-1:0]              fifo_empty,
   output logic                        burst_req,
   output logic                        tail_req,
   output logic [ch_width(NCH)-1:0]    req_ch,
   output logic [LSIZE-1:0]            req_len,
   input  logic                        resp,
   input  logic                        done,
   output logic [NCH-1:0]              burst_done,
   output logic [NCH-1:0]              tail_done,
   output logic [NCH-1:0]              rst_chain,
   output logic                        busy
);

   localparam int CHW = ch_width(NCH);

   logic [NCH-1:0]   burst_ok, tail_pend, req_vec, rchain_clr;
   logic [LSIZE-1:0] chan_len [NCH];

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      fifo_status_chan #(
         .CW(CW), .THRESHOLD(THRESHOLD), .LSIZE(LSIZE), .MODE(MODE)
      ) u_chan (
         .clock        (clock),
         .rst_n        (rst_n),
         .count_i      (count[i*CW +: CW]),
         .line_tail_i  (line_tail[i]),
         .frame_tail_i (frame_tail[i]),
         .tail_len_i   (tail_len[i*LSIZE +: LSIZE]),
         .clr_i        (f_rst_st[i] | tail_done[i] | rchain_clr[i]),
         .burst_ok_o   (burst_ok[i]),
         .tail_pend_o  (tail_pend[i]),
         .tail_len_o   (chan_len[i])
      );
   end

   assign req_vec = {NCH{enable}} & ~fifo_empty & (tail_pend | burst_ok);

   logic [2:0]       state_q, state_d;
   logic [CHW-1:0]   ptr_q, ptr_d, req_ch_q, req_ch_d, gnt_ch, idx;
   logic             kind_q, kind_d, gnt_found, abort;
   logic [LSIZE-1:0] len_q, len_d;

   // Search starts one past the last finished channel so it has lowest priority next round.
   always_comb begin
      gnt_found = 1'b0;
      gnt_ch    = '0;
      idx       = '0;
      for (int k = 1; k <= NCH; k++) begin
         idx = CHW'((int'(ptr_q) + k) % NCH);
         if (!gnt_found && req_vec[idx]) begin
            gnt_found = 1'b1;
            gnt_ch    = idx;
         end
      end
   end

   assign abort = f_rst_st[req_ch_q];

`ifdef FIFO_STATUS_ARB_TIMEOUT_EN
   logic [TO_W-1:0] to_cnt_q;
   logic            timeout;

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         to_cnt_q <= '0;
      end else if (state_q == ST_REQ || state_q == ST_WAIT) begin
         to_cnt_q <= to_cnt_q + 1'b1;
      end else begin
         to_cnt_q <= '0;
      end
   end

   assign timeout = to_cnt_q > TO_LIMIT;
`else
   logic unused_to;
   assign unused_to = ^TO_LIMIT;
`endif

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         ptr_q    <= '0;
         req_ch_q <= '0;
         kind_q   <= KIND_BURST;
         len_q    <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         req_ch_q <= req_ch_d;
         kind_q   <= kind_d;
         len_q    <= len_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      req_ch_d = req_ch_q;
      kind_d   = kind_q;
      len_d    = len_q;
      case (state_q)
         ST_IDLE: state_d = ST_ARB;
         ST_ARB: begin
            if (gnt_found) begin
               state_d  = ST_REQ;
               req_ch_d = gnt_ch;
               kind_d   = tail_pend[gnt_ch] ? KIND_TAIL : KIND_BURST;
               len_d    = tail_pend[gnt_ch] ? chan_len[gnt_ch] : LSIZE'(BURST_LEN);
            end
         end
         ST_REQ, ST_WAIT: begin
            if (abort) state_d = ST_IDLE;
`ifdef FIFO_STATUS_ARB_TIMEOUT_EN
            else if (timeout) state_d = ST_TERR;
`endif
            else if (state_q == ST_REQ) begin
               // A done arriving with resp completes the request without a WAIT cycle.
               if (resp) state_d = done ? ST_FSH : ST_WAIT;
            end else if (done) begin
               state_d = ST_FSH;
            end
         end
         ST_FSH: begin
            state_d = ST_IDLE;
            ptr_d   = req_ch_q;
         end
`ifdef FIFO_STATUS_ARB_TIMEOUT_EN
         ST_TERR: state_d = abort ? ST_IDLE : ST_RCHAIN;
         ST_RCHAIN: if (abort || fifo_empty[req_ch_q]) state_d = ST_IDLE;
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      burst_req  = 1'b0;
      tail_req   = 1'b0;
      req_ch     = '0;
      req_len    = '0;
      busy       = 1'b0;
      burst_done = '0;
      tail_done  = '0;
      rst_chain  = '0;
      rchain_clr = '0;
      case (state_q)
         ST_REQ: begin
            burst_req = (kind_q == KIND_BURST);
            tail_req  = (kind_q == KIND_TAIL);
         end
         ST_FSH: begin
            if (kind_q == KIND_TAIL) tail_done[req_ch_q] = 1'b1;
            else                     burst_done[req_ch_q] = 1'b1;
         end
`ifdef FIFO_STATUS_ARB_TIMEOUT_EN
         ST_TERR:   rst_chain[req_ch_q]  = 1'b1;
         ST_RCHAIN: rchain_clr[req_ch_q] = fifo_empty[req_ch_q];
`endif
         default: ;
      endcase
      if (state_q != ST_IDLE && state_q != ST_ARB) begin
         busy    = 1'b1;
         req_ch  = req_ch_q;
         req_len = len_q;
      end
   end

endmodule

// File: tb/tb_fifo_status_arb.sv
// tb/tb_fifo_status_arb.sv - scoreboard bench for fifo_status_arb (NCH=4, TO_LIMIT=16)
module tb_fifo_status_arb;

   typedef struct {int ch; bit tl; int len;} req_t;
   typedef struct {int ch; bit tl;} dn_t;

   logic        clock = 1'b0;
   logic        rst_n, enable, resp, done;
   logic [3:0]  f_rst_st, line_tail, frame_tail, fifo_empty;
   logic [39:0] count;
   logic [35:0] tail_len;
   logic        burst_req, tail_req, busy;
   logic [1:0]  req_ch;
   logic [8:0]  req_len;
   logic [3:0]  burst_done, tail_done, rst_chain;

   int   checks = 0;
   int   errors = 0;
   int   mdl_ptr = 0;
   req_t exp_q[$];
   dn_t  done_q[$];
   int   rc_q[$];

   fifo_status_arb #(
      .NCH(4), .CW(10), .THRESHOLD(200), .BURST_LEN(100), .LSIZE(9),
      .MODE("LINE"), .TO_W(24), .TO_LIMIT(24'd16)
   ) dut (
      .clock(clock), .rst_n(rst_n), .enable(enable), .f_rst_st(f_rst_st), .count(count),
      .line_tail(line_tail), .frame_tail(frame_tail), .tail_len(tail_len),
      .fifo_empty(fifo_empty), .burst_req(burst_req), .tail_req(tail_req), .req_ch(req_ch),
      .req_len(req_len), .resp(resp), .done(done), .burst_done(burst_done),
      .tail_done(tail_done), .rst_chain(rst_chain), .busy(busy)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      for (int i = 0; i < 4; i++) begin
         if (burst_done[i] || tail_done[i]) done_q.push_back('{i, tail_done[i]});
         if (rst_chain[i]) rc_q.push_back(i);
      end
      checks++;
      if (!$onehot0({burst_done, tail_done})) begin
         errors++;
         $display("FAIL done_onehot: burst_done=%b tail_done=%b, required at most one bit", burst_done, tail_done);
      end
      checks++;
      if (burst_req && tail_req) begin
         errors++;
         $display("FAIL req_exclusive: burst_req=1 tail_req=1, required not both");
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   function automatic int rr_pick(input int ptr, input logic [3:0] reqs);
      for (int k = 1; k <= 4; k++) if (reqs[(ptr + k) % 4]) return (ptr + k) % 4;
      return -1;
   endfunction

   task automatic tick();
      @(posedge clock); #1;
   endtask

   task automatic set_count(input int ch, input int v);
      count[ch*10 +: 10] = 10'(v);
   endtask

   task automatic wait_req(input int limit, output bit got, output req_t o, output int lat);
      got = 1'b0; o = '{0, 1'b0, 0}; lat = 0;
      for (int c = 0; c < limit && !got; c++) begin
         @(negedge clock);
         if (burst_req || tail_req) begin
            got = 1'b1; o = '{int'(req_ch), tail_req, int'(req_len)}; lat = c;
         end
      end
   endtask

   task automatic engine_ack(input int gap);
      resp = 1'b1; tick(); resp = 1'b0;
      repeat (gap) tick();
      done = 1'b1; tick(); done = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; set_count(1, 300);
      repeat (3) tick();
      @(negedge clock);
      checks++;
      if (busy !== 1'b0 || burst_req !== 1'b0 || tail_req !== 1'b0) begin
         errors++; $display("FAIL reset_req: busy=%b burst_req=%b tail_req=%b, required 0", busy, burst_req, tail_req);
      end
      checks++;
      if ({burst_done, tail_done, rst_chain} !== 12'h0 || req_len !== 9'd0 || req_ch !== 2'd0) begin
         errors++; $display("FAIL reset_out: done=%b/%b rst_chain=%b len=%0d ch=%0d, required 0", burst_done, tail_done, rst_chain, req_len, req_ch);
      end
      count = '0; rst_n = 1'b1; mdl_ptr = 0;
      repeat (3) tick();
   endtask

   task automatic test_single_burst();
      bit got; req_t o, e; int lat;
      done_q.delete();
      set_count(2, 201);
      exp_q.push_back('{2, 1'b0, 100});
      wait_req(10, got, o, lat);
      e = exp_q.pop_front();
      checks++;
      if (!got || o.ch != e.ch || o.tl != e.tl || o.len != e.len) begin
         errors++; $display("FAIL single_req: got=%b ch=%0d tail=%b len=%0d, required ch=%0d tail=%b len=%0d", got, o.ch, o.tl, o.len, e.ch, e.tl, e.len);
      end
      checks++;
      if (lat != 2 || busy !== 1'b1) begin
         errors++; $display("FAIL single_latency: latency=%0d busy=%b, required 2 and 1", lat, busy);
      end
      resp = 1'b1; tick(); resp = 1'b0;
      @(negedge clock);
      checks++;
      if (burst_req !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL single_wait: burst_req=%b busy=%b, required 0 and 1", burst_req, busy);
      end
      done = 1'b1; tick(); done = 1'b0;
      set_count(2, 0);
      repeat (4) tick();
      checks++;
      if (done_q.size() != 1 || done_q[0].ch != 2 || done_q[0].tl != 1'b0) begin
         errors++; $display("FAIL single_done: pulses=%0d first_ch=%0d, required one burst_done on ch 2", done_q.size(), (done_q.size() > 0) ? done_q[0].ch : -1);
      end
      mdl_ptr = 2;
   endtask

   task automatic test_round_robin();
      bit got; req_t o, e; int lat; int grants[4];
      done_q.delete();
      set_count(0, 300); set_count(3, 300);
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back('{rr_pick(mdl_ptr, 4'b1001), 1'b0, 100});
         wait_req(10, got, o, lat);
         e = exp_q.pop_front();
         checks++;
         if (!got || o.ch != e.ch || o.tl != e.tl || o.len != e.len) begin
            errors++; $display("FAIL rr_grant%0d: got=%b ch=%0d len=%0d, required ch=%0d len=%0d", i, got, o.ch, o.len, e.ch, e.len);
         end
         engine_ack(1);
         mdl_ptr = e.ch; grants[i] = e.ch;
      end
      set_count(0, 0); set_count(3, 0);
      repeat (4) tick();
      checks++;
      if (done_q.size() != 4) begin
         errors++; $display("FAIL rr_done_count: pulses=%0d, required 4", done_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (done_q[i].ch != grants[i] || done_q[i].tl != 1'b0) begin
               errors++; $display("FAIL rr_done%0d: ch=%0d tail=%b, required ch=%0d burst", i, done_q[i].ch, done_q[i].tl, grants[i]);
            end
         end
      end
   endtask

   task automatic test_tail_then_burst();
      bit got; req_t o, e; int lat;
      done_q.delete();
      enable = 1'b0;
      set_count(1, 250);
      tail_len[9 +: 9] = 9'd37; line_tail[1] = 1'b1; frame_tail[2] = 1'b1;
      tick();
      tail_len[9 +: 9] = 9'd55; frame_tail = '0;
      tick();
      line_tail = '0; enable = 1'b1;
      exp_q.push_back('{1, 1'b1, 37});
      exp_q.push_back('{1, 1'b0, 100});
      for (int i = 0; i < 2; i++) begin
         wait_req(10, got, o, lat);
         e = exp_q.pop_front();
         checks++;
         if (!got || o.ch != e.ch || o.tl != e.tl || o.len != e.len) begin
            errors++; $display("FAIL tail_req%0d: got=%b ch=%0d tail=%b len=%0d, required ch=%0d tail=%b len=%0d", i, got, o.ch, o.tl, o.len, e.ch, e.tl, e.len);
         end
         engine_ack(0);
      end
      set_count(1, 0);
      repeat (4) tick();
      checks++;
      if (done_q.size() != 2 || done_q[0].ch != 1 || done_q[0].tl != 1'b1 || done_q[1].ch != 1 || done_q[1].tl != 1'b0) begin
         errors++; $display("FAIL tail_done: pulses=%0d, required tail_done[1] then burst_done[1]", done_q.size());
      end
      wait_req(8, got, o, lat);
      checks++;
      if (got) begin
         errors++; $display("FAIL tail_stray: request ch=%0d tail=%b, required none", o.ch, o.tl);
      end
      mdl_ptr = 1;
   endtask

   task automatic test_abort();
      bit got; req_t o, e; int lat;
      done_q.delete();
      set_count(1, 300);
      exp_q.push_back('{rr_pick(mdl_ptr, 4'b0010), 1'b0, 100});
      wait_req(10, got, o, lat);
      e = exp_q.pop_front();
      checks++;
      if (!got || o.ch != e.ch || o.len != e.len) begin
         errors++; $display("FAIL abort_req: got=%b ch=%0d len=%0d, required ch=%0d len=%0d", got, o.ch, o.len, e.ch, e.len);
      end
      resp = 1'b1; tick(); resp = 1'b0;
      f_rst_st[1] = 1'b1; tick(); f_rst_st = '0;
      @(negedge clock);
      checks++;
      if (busy !== 1'b0 || burst_req !== 1'b0 || tail_req !== 1'b0 || req_len !== 9'd0) begin
         errors++; $display("FAIL abort_clear: busy=%b burst_req=%b len=%0d, required 0", busy, burst_req, req_len);
      end
      exp_q.push_back('{rr_pick(mdl_ptr, 4'b0010), 1'b0, 100});
      wait_req(10, got, o, lat);
      e = exp_q.pop_front();
      checks++;
      if (!got || o.ch != e.ch || o.len != e.len) begin
         errors++; $display("FAIL abort_regrant: got=%b ch=%0d len=%0d, required ch=%0d len=%0d", got, o.ch, o.len, e.ch, e.len);
      end
      engine_ack(0);
      set_count(1, 0);
      repeat (4) tick();
      checks++;
      if (done_q.size() != 1 || done_q[0].ch != 1) begin
         errors++; $display("FAIL abort_done: pulses=%0d, required exactly one on ch 1", done_q.size());
      end
      mdl_ptr = 1;
   endtask

   task automatic test_resp_done_same();
      bit got; req_t o, e; int lat;
      done_q.delete();
      set_count(2, 300);
      exp_q.push_back('{rr_pick(mdl_ptr, 4'b0100), 1'b0, 100});
      wait_req(10, got, o, lat);
      e = exp_q.pop_front();
      checks++;
      if (!got || o.ch != e.ch || o.len != e.len) begin
         errors++; $display("FAIL same_req: got=%b ch=%0d len=%0d, required ch=%0d len=%0d", got, o.ch, o.len, e.ch, e.len);
      end
      done = 1'b1; tick(); done = 1'b0;
      @(negedge clock);
      checks++;
      if (burst_req !== 1'b1) begin
         errors++; $display("FAIL early_done: burst_req=%b, required 1 (done without resp ignored)", burst_req);
      end
      resp = 1'b1; done = 1'b1; tick(); resp = 1'b0; done = 1'b0;
      set_count(2, 0);
      repeat (4) tick();
      checks++;
      if (done_q.size() != 1 || done_q[0].ch != 2 || done_q[0].tl != 1'b0) begin
         errors++; $display("FAIL same_done: pulses=%0d, required one burst_done on ch 2", done_q.size());
      end
      mdl_ptr = 2;
   endtask

   task automatic test_timeout();
      bit got; req_t o, e; int lat; int dly; bit seen;
      done_q.delete(); rc_q.delete();
      set_count(3, 300);
      exp_q.push_back('{rr_pick(mdl_ptr, 4'b1000), 1'b0, 100});
      wait_req(10, got, o, lat);
      e = exp_q.pop_front();
      checks++;
      if (!got || o.ch != e.ch || o.len != e.len) begin
         errors++; $display("FAIL to_req: got=%b ch=%0d len=%0d, required ch=%0d len=%0d", got, o.ch, o.len, e.ch, e.len);
      end
`ifdef FIFO_STATUS_ARB_TIMEOUT_EN
      seen = 1'b0; dly = 0;
      for (int c = 1; c <= 40 && !seen; c++) begin
         @(negedge clock);
         if (rst_chain != 4'b0) begin seen = 1'b1; dly = c; end
      end
      checks++;
      if (!seen || dly != 18 || rst_chain !== 4'b1000) begin
         errors++; $display("FAIL to_pulse: seen=%b delay=%0d rst_chain=%b, required delay 18 on 1000", seen, dly, rst_chain);
      end
      @(negedge clock);
      checks++;
      if (busy !== 1'b1 || rst_chain !== 4'b0) begin
         errors++; $display("FAIL to_rchain: busy=%b rst_chain=%b, required 1 and 0000", busy, rst_chain);
      end
      tick();
      fifo_empty[3] = 1'b1; set_count(3, 0);
      tick();
      @(negedge clock);
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL to_idle: busy=%b, required 0 after fifo_empty", busy);
      end
      fifo_empty = '0;
      repeat (3) tick();
      checks++;
      if (done_q.size() != 0 || rc_q.size() != 1) begin
         errors++; $display("FAIL to_counts: done pulses=%0d rst_chain pulses=%0d, required 0 and 1", done_q.size(), rc_q.size());
      end
`else
      seen = 1'b0; dly = 0;
      repeat (30) tick();
      @(negedge clock);
      checks++;
      if (burst_req !== 1'b1 || rc_q.size() != 0) begin
         errors++; $display("FAIL no_timeout: burst_req=%b rst_chain pulses=%0d, required 1 and 0", burst_req, rc_q.size());
      end
      engine_ack(0);
      set_count(3, 0);
      repeat (4) tick();
      checks++;
      if (done_q.size() != 1 || done_q[0].ch != 3) begin
         errors++; $display("FAIL no_timeout_done: pulses=%0d, required one on ch 3", done_q.size());
      end
      mdl_ptr = 3;
`endif
   endtask

   task automatic test_threshold_enable();
      bit got; req_t o, e; int lat;
      set_count(0, 200);
      wait_req(10, got, o, lat);
      checks++;
      if (got) begin errors++; $display("FAIL threshold_strict: request ch=%0d at count 200, required none", o.ch); end
      set_count(0, 201); enable = 1'b0;
      wait_req(10, got, o, lat);
      checks++;
      if (got) begin errors++; $display("FAIL enable_block: request ch=%0d with enable=0, required none", o.ch); end
      enable = 1'b1; fifo_empty[0] = 1'b1;
      wait_req(10, got, o, lat);
      checks++;
      if (got) begin errors++; $display("FAIL empty_block: request ch=%0d with fifo_empty, required none", o.ch); end
      fifo_empty[0] = 1'b0;
      exp_q.push_back('{rr_pick(mdl_ptr, 4'b0001), 1'b0, 100});
      wait_req(10, got, o, lat);
      e = exp_q.pop_front();
      checks++;
      if (!got || o.ch != e.ch || o.len != e.len) begin
         errors++; $display("FAIL threshold_201: got=%b ch=%0d len=%0d, required ch=%0d len=%0d", got, o.ch, o.len, e.ch, e.len);
      end
      engine_ack(0);
      set_count(0, 0);
      repeat (4) tick();
      mdl_ptr = 0;
   endtask

   task automatic test_reset_mid();
      bit got; req_t o; int lat;
      set_count(1, 300);
      wait_req(10, got, o, lat);
      checks++;
      if (!got || o.ch != 1) begin
         errors++; $display("FAIL midreset_req: got=%b ch=%0d, required ch 1", got, o.ch);
      end
      rst_n = 1'b0; set_count(1, 0);
      tick();
      rst_n = 1'b1;
      @(negedge clock);
      checks++;
      if (busy !== 1'b0 || burst_req !== 1'b0) begin
         errors++; $display("FAIL midreset_clear: busy=%b burst_req=%b, required 0", busy, burst_req);
      end
      wait_req(6, got, o, lat);
      checks++;
      if (got) begin errors++; $display("FAIL midreset_stray: request ch=%0d, required none", o.ch); end
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b1; resp = 1'b0; done = 1'b0;
      f_rst_st = '0; line_tail = '0; frame_tail = '0; fifo_empty = '0;
      count = '0; tail_len = '0;
      test_reset();
      test_single_burst();
      test_round_robin();
      test_tail_then_burst();
      test_abort();
      test_resp_done_same();
      test_timeout();
      test_threshold_enable();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
